falafel_free_list_walker: RTL and testbench
===========================================

# falafel_free_list_walker

Sequential first-fit search engine for the allocator's singly linked free list. On an allocation request it walks the list through a single read port, fetching each free block's header (size word, then next-pointer word). Each header goes through a `falafel_block_parser` instance, which returns null/fit flags. The walker stops at the first block that fits, or at the end of the list. It sits between the allocator control FSM (upstream, request/response) and the memory read port (downstream), and feeds the block parser.

## Interface
- `WORD_BYTES`, 8: byte offset of the next-pointer word from the block base; block header is {size @ +0, next_ptr @ +WORD_BYTES}.
- `MAX_HOPS`, 1024: maximum blocks examined per request; used only when `FALAFEL_WALK_HOP_LIMIT_EN` is defined.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  search request valid.
- `req_ready_o`  out  1  walker idle, request accepted when both high.
- `req_size_i`  in  word_t  requested size.
- `req_head_ptr_i`  in  word_t  free-list head pointer.
- `mem_req_o`  out  1  read request.
- `mem_addr_o`  out  word_t  read address.
- `mem_gnt_i`  in  1  read request accepted.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  word_t  read data.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  result consumed.
- `rsp_found_o`  out  1  a fitting block was found.
- `rsp_err_o`  out  1  hop limit hit (0 when feature compiled out).
- `rsp_block_ptr_o`  out  word_t  fitting block base (NULL_PTR if not found).
- `rsp_prev_ptr_o`  out  word_t  predecessor block base (NULL_PTR if fit is the head).
- `rsp_block_size_o`  out  word_t  size field of the fitting block.
- `rsp_next_ptr_o`  out  word_t  next_ptr field of the fitting block.

## Operation
- States: IDLE, RD_SIZE, WT_SIZE, RD_NEXT, WT_NEXT, CHECK, RESP.
- IDLE: `req_ready_o`=1. On accept, latch size, set cur=`req_head_ptr_i`, prev=NULL_PTR, hops=0. If the head is NULL_PTR, go to RESP with found=0 and issue no reads; otherwise go to RD_SIZE.
- RD_SIZE: `mem_req_o`=1 with addr=cur, held stable until `mem_gnt_i`, then go to WT_SIZE.
- WT_SIZE: on `mem_rvalid_i`, latch size, then go to RD_NEXT.
- RD_NEXT: `mem_req_o`=1 with addr=cur+WORD_BYTES (modulo word width), held stable until `mem_gnt_i`, then go to WT_NEXT.
- WT_NEXT: on `mem_rvalid_i`, latch next_ptr, then go to CHECK.
- CHECK: the parser evaluates {size, next_ptr} against the request size and hops is incremented.
  - If is_big_enough (size ≥ request, unsigned, so equality fits): found=1, go to RESP.
  - Else if is_null: found=0, go to RESP.
  - Else: prev←cur, cur←next_ptr, go to RD_SIZE.
- RESP: `rsp_valid_o`=1 and all `rsp_*` stable until `rsp_ready_i`, then go to IDLE.
- Exactly one read is outstanding at a time. `mem_rvalid_i` outside the WT states is ignored.
- Reset value of every output is 0, except `rsp_block_ptr_o` and `rsp_prev_ptr_o`, which reset to NULL_PTR. State resets to IDLE.

## Timing
- Request accepted at edge 0. With zero-wait memory (gnt in the request cycle, rvalid the next cycle), a fit in the head block gives `rsp_valid_o`=1 in cycle 6.
- Each additional block examined adds 5 cycles. A NULL head gives `rsp_valid_o` in cycle 1.
- `req_ready_o` is 0 from the cycle after accept until the RESP handshake completes. IDLE is re-entered the cycle after `rsp_valid_o`&`rsp_ready_i`.
- Memory stall: the address holds while gnt=0, and the WT states wait indefinitely.
- Reset asserted mid-walk: immediate return to IDLE with outputs at reset values. A late rvalid arriving afterwards is ignored.
- A cyclic list never terminates unless the hop limit is compiled in.

## Configuration
- `FALAFEL_WALK_HOP_LIMIT_EN` defined:
  - hops counter of $clog2(MAX_HOPS+1) bits.
  - If CHECK finds no fit, next is non-null and hops reaches MAX_HOPS, go to RESP with found=0, err=1, block_ptr=NULL_PTR.
- Not defined: no counter, `rsp_err_o` tied 0, walk is bounded only by NULL_PTR.

## Test plan
- Head=NULL_PTR, size=16 -> in cycle 1, found=0, err=0, block_ptr=NULL_PTR; zero `mem_req_o` pulses.
- List 0x100(size 8)→0x200(size 32)→NULL, size=16 -> found=1, block=0x200, prev=0x100, block_size=32, next=NULL_PTR; 4 reads; `rsp_valid_o` in cycle 11.
- Same list, size=64 -> found=0 after 4 reads at addresses 0x100, 0x108, 0x200, 0x208.
- Head 0x100 size 16, request 16 -> exact fit: found=1, prev=NULL_PTR; random gnt/rvalid delays 0-5 cycles give identical result.
- Reset pulsed while in WT_NEXT with rvalid returned 2 cycles later -> outputs at reset values, next request (head 0x300 size 40, size=8) completes correctly.
- With macro, MAX_HOPS=4, cyclic list 0x100→0x200→0x100 of size 8, size=16 -> found=0, err=1 after 8 reads; without macro, still searching after 1000 cycles.

Source files
------------

// File: rtl/falafel_free_list_walker.sv
// falafel_free_list_walker
// First-fit search over the allocator's singly linked free list. Each block
// header is {size @ +0, next_ptr @ +WORD_BYTES}. One read is outstanding at a
// time. The walk stops at the first block whose size covers the request, or
// at the end of the list.
//
// Optional feature: define FALAFEL_WALK_HOP_LIMIT_EN to bound the number of
// blocks examined per request to MAX_HOPS. If the bound is hit, the response
// has rsp_err_o=1. Without the macro rsp_err_o is tied low and a cyclic list
// never terminates.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o search request handshake
//   req_size_i              requested size
//   req_head_ptr_i          free-list head pointer
//   mem_req_o/mem_gnt_i     read request handshake, address on mem_addr_o
//   mem_rvalid_i/rdata_i    read return
//   rsp_valid_o/rsp_ready_i result handshake
//   rsp_found_o, rsp_err_o  outcome flags
//   rsp_block_ptr_o         fitting block base (NULL_PTR if none)
//   rsp_prev_ptr_o          predecessor of the fitting block (NULL_PTR if head)
//   rsp_block_size_o        size field of the fitting block
//   rsp_next_ptr_o          next_ptr field of the fitting block
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | ready for a request
// RD_SIZE | read request for the size word at cur
// WT_SIZE | waiting for the size word
// RD_NEXT | read request for the next_ptr word at cur+WORD_BYTES
// WT_NEXT | waiting for the next_ptr word
// CHECK   | parser decides fit / end of list / advance
// RESP    | result held until consumed

module falafel_block_parser #(
   parameter int WORD_W = 32
) (
   input  logic [WORD_W-1:0] size,
   input  logic [WORD_W-1:0] next_ptr,
   input  logic [WORD_W-1:0] req_size,
   output logic              is_null,
   output logic              is_big_enough
);
   assign is_null       = (next_ptr == '0);
   assign is_big_enough = (size >= req_size);
endmodule

module falafel_free_list_walker #(
   parameter int WORD_W     = 32,
   parameter int WORD_BYTES = 8,
   parameter int MAX_HOPS   = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [WORD_W-1:0] req_size_i,
   input  logic [WORD_W-1:0] req_head_ptr_i,
   output logic              mem_req_o,
   output logic [WORD_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [WORD_W-1:0] mem_rdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_found_o,
   output logic              rsp_err_o,
   output logic [WORD_W-1:0] rsp_block_ptr_o,
   output logic [WORD_W-1:0] rsp_prev_ptr_o,
   output logic [WORD_W-1:0] rsp_block_size_o,
   output logic [WORD_W-1:0] rsp_next_ptr_o
);
   localparam logic [WORD_W-1:0] NULL_PTR = '0;
   localparam logic [WORD_W-1:0] NEXT_OFS = WORD_W'(WORD_BYTES);

   typedef enum logic [2:0] {
      IDLE, RD_SIZE, WT_SIZE, RD_NEXT, WT_NEXT, CHECK, RESP
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] req_size_q;
   logic [WORD_W-1:0] cur_q;
   logic [WORD_W-1:0] prev_q;
   logic [WORD_W-1:0] size_q;
   logic [WORD_W-1:0] next_q;
   logic              is_null;
   logic              is_big_enough;

   falafel_block_parser #(.WORD_W(WORD_W)) u_parser (
      .size          (size_q),
      .next_ptr      (next_q),
      .req_size      (req_size_q),
      .is_null       (is_null),
      .is_big_enough (is_big_enough)
   );

`ifdef FALAFEL_WALK_HOP_LIMIT_EN
   localparam int HOP_W = $clog2(MAX_HOPS + 1);
   logic [HOP_W-1:0] hops_q;
   logic [HOP_W-1:0] hops_inc;
   logic             err_q;
   assign hops_inc  = hops_q + HOP_W'(1);
   assign rsp_err_o = err_q;
`else
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         req_ready_o      <= 1'b0;
         mem_req_o        <= 1'b0;
         mem_addr_o       <= '0;
         rsp_valid_o      <= 1'b0;
         rsp_found_o      <= 1'b0;
         rsp_block_ptr_o  <= NULL_PTR;
         rsp_prev_ptr_o   <= NULL_PTR;
         rsp_block_size_o <= '0;
         rsp_next_ptr_o   <= '0;
         req_size_q       <= '0;
         cur_q            <= NULL_PTR;
         prev_q           <= NULL_PTR;
         size_q           <= '0;
         next_q           <= '0;
`ifdef FALAFEL_WALK_HOP_LIMIT_EN
         hops_q           <= '0;
         err_q            <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // ready rises one cycle after reset release
               req_ready_o <= 1'b1;
               if (req_valid_i && req_ready_o) begin
                  req_ready_o <= 1'b0;
                  req_size_q  <= req_size_i;
                  cur_q       <= req_head_ptr_i;
                  prev_q      <= NULL_PTR;
`ifdef FALAFEL_WALK_HOP_LIMIT_EN
                  hops_q      <= '0;
                  err_q       <= 1'b0;
`endif
                  if (req_head_ptr_i == NULL_PTR) begin
                     rsp_valid_o      <= 1'b1;
                     rsp_found_o      <= 1'b0;
                     rsp_block_ptr_o  <= NULL_PTR;
                     rsp_prev_ptr_o   <= NULL_PTR;
                     rsp_block_size_o <= '0;
                     rsp_next_ptr_o   <= '0;
                     state            <= RESP;
                  end else begin
                     mem_req_o  <= 1'b1;
                     mem_addr_o <= req_head_ptr_i;
                     state      <= RD_SIZE;
                  end
               end
            end
            RD_SIZE: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state     <= WT_SIZE;
               end
            end
            WT_SIZE: begin
               if (mem_rvalid_i) begin
                  size_q     <= mem_rdata_i;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= cur_q + NEXT_OFS;
                  state      <= RD_NEXT;
               end
            end
            RD_NEXT: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state     <= WT_NEXT;
               end
            end
            WT_NEXT: begin
               if (mem_rvalid_i) begin
                  next_q <= mem_rdata_i;
                  state  <= CHECK;
               end
            end
            CHECK: begin
`ifdef FALAFEL_WALK_HOP_LIMIT_EN
               hops_q <= hops_inc;
`endif
               if (is_big_enough) begin
                  rsp_valid_o      <= 1'b1;
                  rsp_found_o      <= 1'b1;
                  rsp_block_ptr_o  <= cur_q;
                  rsp_prev_ptr_o   <= prev_q;
                  rsp_block_size_o <= size_q;
                  rsp_next_ptr_o   <= next_q;
                  state            <= RESP;
               end else if (is_null) begin
                  rsp_valid_o      <= 1'b1;
                  rsp_found_o      <= 1'b0;
                  rsp_block_ptr_o  <= NULL_PTR;
                  rsp_prev_ptr_o   <= NULL_PTR;
                  rsp_block_size_o <= '0;
                  rsp_next_ptr_o   <= '0;
                  state            <= RESP;
`ifdef FALAFEL_WALK_HOP_LIMIT_EN
               end else if (hops_inc == HOP_W'(MAX_HOPS)) begin
                  rsp_valid_o      <= 1'b1;
                  rsp_found_o      <= 1'b0;
                  err_q            <= 1'b1;
                  rsp_block_ptr_o  <= NULL_PTR;
                  rsp_prev_ptr_o   <= NULL_PTR;
                  rsp_block_size_o <= '0;
                  rsp_next_ptr_o   <= '0;
                  state            <= RESP;
`endif
               end else begin
                  prev_q     <= cur_q;
                  cur_q      <= next_q;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= next_q;
                  state      <= RD_SIZE;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_falafel_free_list_walker.sv
module tb_falafel_free_list_walker;
   localparam int MAX_HOPS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_size = '0;
   logic [31:0] req_head = '0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid_o;
   logic        rsp_ready = 1'b0;
   logic        rsp_found_o;
   logic        rsp_err_o;
   logic [31:0] rsp_block_ptr_o;
   logic [31:0] rsp_prev_ptr_o;
   logic [31:0] rsp_block_size_o;
   logic [31:0] rsp_next_ptr_o;

   int checks = 0;
   int failures = 0;

   falafel_free_list_walker #(.WORD_W(32), .WORD_BYTES(8), .MAX_HOPS(MAX_HOPS)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready_o),
      .req_size_i       (req_size),
      .req_head_ptr_i   (req_head),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_gnt_i        (mem_gnt),
      .mem_rvalid_i     (mem_rvalid),
      .mem_rdata_i      (mem_rdata),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready),
      .rsp_found_o      (rsp_found_o),
      .rsp_err_o        (rsp_err_o),
      .rsp_block_ptr_o  (rsp_block_ptr_o),
      .rsp_prev_ptr_o   (rsp_prev_ptr_o),
      .rsp_block_size_o (rsp_block_size_o),
      .rsp_next_ptr_o   (rsp_next_ptr_o)
   );

   initial forever #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // memory image and read responder
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_q[$];
   logic [31:0] exp_q[$];
   bit          rand_dly = 0;
   int          fixed_rv = 0;
   int          n_reads = 0;

   initial begin
      bit          pend = 0;
      bit          waiting = 0;
      logic [31:0] pend_addr = '0;
      logic [31:0] hold_addr = '0;
      int          rv_cnt = 0;
      int          gnt_cnt = 0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (pend) begin
            if (rv_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
               pend = 0;
            end else rv_cnt--;
         end else if (mem_req_o && !rst) begin
            if (waiting) check_val("addr_hold", mem_addr_o, hold_addr);
            if (gnt_cnt == 0) begin
               mem_gnt = 1'b1;
               pend = 1;
               waiting = 0;
               pend_addr = mem_addr_o;
               rd_q.push_back(mem_addr_o);
               n_reads++;
               rv_cnt  = rand_dly ? int'($urandom_range(0, 5)) : fixed_rv;
               gnt_cnt = rand_dly ? int'($urandom_range(0, 5)) : 0;
            end else begin
               waiting = 1;
               hold_addr = mem_addr_o;
               gnt_cnt--;
            end
         end else waiting = 0;
      end
   end

   // first-fit reference: follow the list in the memory image
   function automatic void model(input logic [31:0] head, input logic [31:0] size,
                                 input bit hop_en,
                                 output bit found, output bit err,
                                 output logic [31:0] blk, output logic [31:0] prv,
                                 output logic [31:0] bsz, output logic [31:0] nxt);
      logic [31:0] cur = head;
      logic [31:0] p = 32'h0;
      logic [31:0] s, n;
      int hops = 0;
      found = 0; err = 0; blk = 0; prv = 0; bsz = 0; nxt = 0;
      exp_q.delete();
      while (cur != 0 && hops < 5000) begin
         s = mem.exists(cur) ? mem[cur] : 32'h0;
         n = mem.exists(cur + 32'd8) ? mem[cur + 32'd8] : 32'h0;
         exp_q.push_back(cur);
         exp_q.push_back(cur + 32'd8);
         hops++;
         if (s >= size) begin
            found = 1; blk = cur; prv = p; bsz = s; nxt = n;
            return;
         end
         if (n == 0) return;
         if (hop_en && hops == MAX_HOPS) begin
            err = 1;
            return;
         end
         p = cur;
         cur = n;
      end
   endfunction

   task automatic do_req(input logic [31:0] head, input logic [31:0] size, output int cyc);
      int n = 0;
      rd_q.delete();
      n_reads = 0;
      req_head = head;
      req_size = size;
      req_valid = 1'b1;
      while (!req_ready_o && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      @(posedge clk); #2;
      req_valid = 1'b0;
      check_val("ready_low", {31'h0, req_ready_o}, 32'h0);
      cyc = 1;
      while (!rsp_valid_o && cyc < 3000) begin
         @(posedge clk); #2;
         cyc++;
      end
      if (!rsp_valid_o) check_val("rsp_timeout", 32'h0, 32'h1);
   endtask

   task automatic finish_rsp();
      int d = int'($urandom_range(0, 2));
      logic [31:0] blk = rsp_block_ptr_o;
      for (int i = 0; i < d; i++) begin
         @(posedge clk); #2;
      end
      check_val("rsp_hold", rsp_block_ptr_o, blk);
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      rsp_ready = 1'b0;
      check_val("ready_back", {31'h0, req_ready_o}, 32'h1);
      check_val("valid_drop", {31'h0, rsp_valid_o}, 32'h0);
   endtask

   task automatic check_model(input string tag, input logic [31:0] head, input logic [31:0] size, input bit hop_en);
      bit f, e;
      logic [31:0] b, p, s, n;
      model(head, size, hop_en, f, e, b, p, s, n);
      check_val({tag, "_found"}, {31'h0, rsp_found_o}, {31'h0, f});
      check_val({tag, "_err"}, {31'h0, rsp_err_o}, {31'h0, e});
      check_val({tag, "_blk"}, rsp_block_ptr_o, b);
      if (f) begin
         check_val({tag, "_prev"}, rsp_prev_ptr_o, p);
         check_val({tag, "_bsize"}, rsp_block_size_o, s);
         check_val({tag, "_next"}, rsp_next_ptr_o, n);
      end
      check_val({tag, "_nreads"}, n_reads, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
         check_val({tag, "_addr"}, rd_q[i], exp_q[i]);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_ready"}, {31'h0, req_ready_o}, 32'h0);
      check_val({tag, "_memreq"}, {31'h0, mem_req_o}, 32'h0);
      check_val({tag, "_valid"}, {31'h0, rsp_valid_o}, 32'h0);
      check_val({tag, "_found"}, {31'h0, rsp_found_o}, 32'h0);
      check_val({tag, "_blk"}, rsp_block_ptr_o, 32'h0);
      check_val({tag, "_prev"}, rsp_prev_ptr_o, 32'h0);
   endtask

   initial begin
      int cyc;
      bit hop_en;
`ifdef FALAFEL_WALK_HOP_LIMIT_EN
      hop_en = 1;
`else
      hop_en = 0;
`endif
      #2;
      check_reset_vals("reset");
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      // NULL head
      do_req(32'h0, 32'd16, cyc);
      check_val("null_cyc", cyc, 1);
      check_val("null_found", {31'h0, rsp_found_o}, 32'h0);
      check_val("null_err", {31'h0, rsp_err_o}, 32'h0);
      check_val("null_blk", rsp_block_ptr_o, 32'h0);
      check_val("null_reads", n_reads, 0);
      finish_rsp();

      // two-block list, fit in second block, zero-wait memory
      mem[32'h100] = 32'd8;  mem[32'h108] = 32'h200;
      mem[32'h200] = 32'd32; mem[32'h208] = 32'h0;
      do_req(32'h100, 32'd16, cyc);
      check_val("two_cyc", cyc, 11);
      check_model("two_fit", 32'h100, 32'd16, hop_en);
      check_val("two_blk_k", rsp_block_ptr_o, 32'h200);
      check_val("two_prev_k", rsp_prev_ptr_o, 32'h100);
      finish_rsp();

      do_req(32'h100, 32'd64, cyc);
      check_model("two_miss", 32'h100, 32'd64, hop_en);
      finish_rsp();

      // exact fit in head, zero-wait then random delays
      mem[32'h100] = 32'd16; mem[32'h108] = 32'h0;
      do_req(32'h100, 32'd16, cyc);
      check_val("exact_cyc", cyc, 6);
      check_model("exact", 32'h100, 32'd16, hop_en);
      rand_dly = 1;
      finish_rsp();
      for (int i = 0; i < 3; i++) begin
         do_req(32'h100, 32'd16, cyc);
         check_model("exact_rnd", 32'h100, 32'd16, hop_en);
         finish_rsp();
      end

      // reset during WT_NEXT with a late rvalid
      rand_dly = 0;
      fixed_rv = 2;
      mem[32'h400] = 32'd4; mem[32'h408] = 32'h0;
      req_head = 32'h400; req_size = 32'd8; req_valid = 1'b1;
      n_reads = 0;
      for (int i = 0; i < 50 && n_reads < 2; i++) begin
         @(posedge clk); #2;
         req_valid = 1'b0;
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      @(posedge clk); #2;
      rst = 1'b0;
      fixed_rv = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
      end
      check_val("late_rv_valid", {31'h0, rsp_valid_o}, 32'h0);
      check_val("late_rv_ready", {31'h0, req_ready_o}, 32'h1);
      mem[32'h300] = 32'd40; mem[32'h308] = 32'h0;
      do_req(32'h300, 32'd8, cyc);
      check_model("post_rst", 32'h300, 32'd8, hop_en);
      finish_rsp();

      // randomized lists with random memory delays
      rand_dly = 1;
      for (int t = 0; t < 20; t++) begin
         int nb = int'($urandom_range(1, 5));
         logic [31:0] addrs[5];
         mem.delete();
         for (int i = 0; i < nb; i++)
            addrs[i] = 32'((i + 1) * 32'h40) + ($urandom_range(1, 15) << 12);
         for (int i = 0; i < nb; i++) begin
            mem[addrs[i]] = $urandom_range(1, 64);
            mem[addrs[i] + 32'd8] = (i == nb - 1) ? 32'h0 : addrs[i + 1];
         end
         req_size = $urandom_range(1, 64);
         do_req(addrs[0], req_size, cyc);
         check_model("rnd", addrs[0], req_size, hop_en);
         finish_rsp();
      end

      // cyclic list
      rand_dly = 0;
      mem.delete();
      mem[32'h100] = 32'd8; mem[32'h108] = 32'h200;
      mem[32'h200] = 32'd8; mem[32'h208] = 32'h100;
`ifdef FALAFEL_WALK_HOP_LIMIT_EN
      do_req(32'h100, 32'd16, cyc);
      check_model("cyc_lim", 32'h100, 32'd16, 1);
      check_val("cyc_err_k", {31'h0, rsp_err_o}, 32'h1);
      check_val("cyc_reads_k", n_reads, 8);
      finish_rsp();
`else
      begin
         bit seen = 0;
         req_head = 32'h100; req_size = 32'd16; req_valid = 1'b1;
         @(posedge clk); #2;
         req_valid = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            if (rsp_valid_o) seen = 1;
         end
         check_val("cyc_nolimit", {31'h0, seen}, 32'h0);
         check_val("cyc_err0", {31'h0, rsp_err_o}, 32'h0);
         rst = 1'b1;
         @(posedge clk); #2;
         rst = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
